// File: rtl/operand_fetch_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | operand_fetch_stage_pkg                                              |
// | Shared widths, the r0 index and the operand source encoding.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package operand_fetch_stage_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CTRL_W = 8;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    SRC_ZERO    = 2'd0,
    SRC_BYPASS  = 2'd1,
    SRC_REGFILE = 2'd2
  } op_src_e;

endpackage
`default_nettype wire

// File: rtl/operand_fetch_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | operand_fetch_if                                                     |
// | Upstream, register-file, writeback and downstream signals of the     |
// | operand fetch stage. Rev 1.0                                         |
// +----------------------------------------------------------------------+
interface operand_fetch_if #(
  parameter int DATA_W = operand_fetch_stage_pkg::DATA_W,
  parameter int ADDR_W = operand_fetch_stage_pkg::ADDR_W,
  parameter int CTRL_W = operand_fetch_stage_pkg::CTRL_W
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rs1;
  logic [ADDR_W-1:0] in_rs2;
  logic [ADDR_W-1:0] in_rd;
  logic [CTRL_W-1:0] in_ctrl;
  logic [ADDR_W-1:0] readReg1;
  logic [ADDR_W-1:0] readReg2;
  logic [DATA_W-1:0] readData1;
  logic [DATA_W-1:0] readData2;
  logic              wb_regWrite;
  logic [ADDR_W-1:0] wb_writeReg;
  logic [DATA_W-1:0] wb_writeData;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_op_a;
  logic [DATA_W-1:0] out_op_b;
  logic [ADDR_W-1:0] out_rs1;
  logic [ADDR_W-1:0] out_rs2;
  logic [ADDR_W-1:0] out_rd;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_ctrl,
    output in_ready, readReg1, readReg2,
    input  readData1, readData2,
    input  wb_regWrite, wb_writeReg, wb_writeData, flush, out_ready,
    output out_valid, out_op_a, out_op_b, out_rs1, out_rs2, out_rd, out_ctrl
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_ctrl,
    input  in_ready, readReg1, readReg2,
    output readData1, readData2,
    output wb_regWrite, wb_writeReg, wb_writeData, flush, out_ready,
    input  out_valid, out_op_a, out_op_b, out_rs1, out_rs2, out_rd, out_ctrl
  );
endinterface
`default_nettype wire

// File: rtl/operand_fetch_stage_operand_select.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | operand_select                                                       |
// | Zero / writeback-bypass / register-file choice for one operand.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module operand_select #(
  parameter int DATA_W = operand_fetch_stage_pkg::DATA_W,
  parameter int ADDR_W = operand_fetch_stage_pkg::ADDR_W
) (
  input  wire logic [ADDR_W-1:0] i_src_idx,
  input  wire logic [DATA_W-1:0] i_rf_data,
  input  wire logic              i_wb_en,
  input  wire logic [ADDR_W-1:0] i_wb_reg,
  input  wire logic [DATA_W-1:0] i_wb_data,
  output logic      [DATA_W-1:0] o_data
);
  import operand_fetch_stage_pkg::*;

  op_src_e w_src;

  // r0 wins over a bypass so a stray write to index 0 can never leak out
  always_comb begin
    w_src = SRC_REGFILE;
    if (i_src_idx == ADDR_W'(REG_ZERO)) begin
      w_src = SRC_ZERO;
    end else if (i_wb_en && (i_wb_reg == i_src_idx)) begin
      w_src = SRC_BYPASS;
    end
  end

  always_comb begin
    o_data = i_rf_data;
    case (w_src)
      SRC_ZERO:   o_data = '0;
      SRC_BYPASS: o_data = i_wb_data;
      default:    o_data = i_rf_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/operand_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | operand_fetch_stage                                                  |
// | Single-slot operand fetch with writeback bypass and stall snooping.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module operand_fetch_stage #(
  parameter int DATA_W = operand_fetch_stage_pkg::DATA_W,
  parameter int ADDR_W = operand_fetch_stage_pkg::ADDR_W,
  parameter int CTRL_W = operand_fetch_stage_pkg::CTRL_W
) (
  input  wire logic        clk,
  input  wire logic        reset,
  operand_fetch_if.slave   bus
);
  import operand_fetch_stage_pkg::*;

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [ADDR_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  logic              w_in_ready;
  logic              w_capture;
  logic [DATA_W-1:0] w_sel_a, w_sel_b;

  assign w_in_ready   = !valid_q || bus.out_ready;
  assign w_capture    = bus.in_valid && w_in_ready && !bus.flush;
  assign bus.in_ready = w_in_ready;
  assign bus.readReg1 = bus.in_rs1;
  assign bus.readReg2 = bus.in_rs2;

  operand_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sel_a (
    .i_src_idx (bus.in_rs1),
    .i_rf_data (bus.readData1),
    .i_wb_en   (bus.wb_regWrite),
    .i_wb_reg  (bus.wb_writeReg),
    .i_wb_data (bus.wb_writeData),
    .o_data    (w_sel_a)
  );

  operand_select #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sel_b (
    .i_src_idx (bus.in_rs2),
    .i_rf_data (bus.readData2),
    .i_wb_en   (bus.wb_regWrite),
    .i_wb_reg  (bus.wb_writeReg),
    .i_wb_data (bus.wb_writeData),
    .o_data    (w_sel_b)
  );

  always_comb begin
    valid_d = valid_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (w_capture) begin
      valid_d = 1'b1;
      op_a_d  = w_sel_a;
      op_b_d  = w_sel_b;
      rs1_d   = bus.in_rs1;
      rs2_d   = bus.in_rs2;
      rd_d    = bus.in_rd;
      ctrl_d  = bus.in_ctrl;
    end else if (valid_q && !bus.out_ready) begin
      // Stalled: a writeback to a held source must refresh the operand
      if (bus.wb_regWrite && (bus.wb_writeReg == rs1_q) && (rs1_q != ADDR_W'(REG_ZERO)))
        op_a_d = bus.wb_writeData;
      if (bus.wb_regWrite && (bus.wb_writeReg == rs2_q) && (rs2_q != ADDR_W'(REG_ZERO)))
        op_b_d = bus.wb_writeData;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_op_a  = op_a_q;
  assign bus.out_op_b  = op_b_q;
  assign bus.out_rs1   = rs1_q;
  assign bus.out_rs2   = rs2_q;
  assign bus.out_rd    = rd_q;
  assign bus.out_ctrl  = ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_operand_fetch_stage                                               |
// | Scoreboard bench: register-file model, directed then random traffic. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_operand_fetch_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  operand_fetch_if #(.DATA_W(32), .ADDR_W(5), .CTRL_W(8)) bus ();

  operand_fetch_stage #(.DATA_W(32), .ADDR_W(5), .CTRL_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Register file model: writes commit on the clock edge, reads are combinational
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'(i) * 32'h0101_0101;
      rf[0] <= 32'hdead_0000;
      rf[1] <= 32'h1234_5678;
      rf[2] <= 32'h8765_4321;
    end else if (bus.wb_regWrite) begin
      rf[bus.wb_writeReg] <= bus.wb_writeData;
    end
  end
  assign bus.readData1 = rf[bus.readReg1];
  assign bus.readData2 = rf[bus.readReg2];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // An operand leaving the slot must equal the architectural register value
  function automatic logic [31:0] arch_val(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'd0 : rf[idx];
  endfunction

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [7:0] ctrl;
  } entry_t;
  entry_t sb[$];

  // Monitor: checks handshake every cycle, pops and compares departures
  initial begin
    entry_t e;
    logic   m_ready;
    forever begin
      @(negedge clk);
      if (reset) begin
        sb.delete();
      end else begin
        m_ready = (sb.size() == 0) || bus.out_ready;
        chk("in_ready", 64'(bus.in_ready), 64'(m_ready));
        chk("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
        chk("readReg1", 64'(bus.readReg1), 64'(bus.in_rs1));
        if (bus.flush) begin
          sb.delete();
        end else if (sb.size() != 0 && bus.out_ready) begin
          e = sb.pop_front();
          chk("out_rs1", 64'(bus.out_rs1), 64'(e.rs1));
          chk("out_rs2", 64'(bus.out_rs2), 64'(e.rs2));
          chk("out_rd", 64'(bus.out_rd), 64'(e.rd));
          chk("out_ctrl", 64'(bus.out_ctrl), 64'(e.ctrl));
          chk("out_op_a", 64'(bus.out_op_a), 64'(arch_val(e.rs1)));
          chk("out_op_b", 64'(bus.out_op_b), 64'(arch_val(e.rs2)));
        end
        if (bus.in_valid && m_ready && !bus.flush) begin
          e.rs1 = bus.in_rs1; e.rs2 = bus.in_rs2; e.rd = bus.in_rd; e.ctrl = bus.in_ctrl;
          sb.push_back(e);
        end
      end
    end
  end

  task automatic idle();
    bus.in_valid = 1'b0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0; bus.in_ctrl = '0;
    bus.wb_regWrite = 1'b0; bus.wb_writeReg = '0; bus.wb_writeData = '0;
    bus.flush = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ctrl);
    bus.in_valid = 1'b1; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd; bus.in_ctrl = ctrl;
  endtask

  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    bus.wb_regWrite = 1'b1; bus.wb_writeReg = r; bus.wb_writeData = d;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    tick(); tick();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_op_a", 64'(bus.out_op_a), 64'd0);
    chk("rst_op_b", 64'(bus.out_op_b), 64'd0);
    chk("rst_fields", {bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_ctrl}, 64'd0);
    reset = 1'b0;

    // Plain register-file read, then a same-cycle bypass on rs1=4
    idle(); issue(5'd1, 5'd2, 5'd3, 8'h5a); tick();
    idle(); issue(5'd4, 5'd1, 5'd6, 8'h11); wb(5'd4, 32'h8765_abcd); tick();

    // Stall with rs2=5 held while r5 is written back
    idle(); issue(5'd2, 5'd5, 5'd7, 8'h22); tick();
    idle(); bus.out_ready = 1'b0; wb(5'd5, 32'ha1b2_c3d4); tick();
    idle(); bus.out_ready = 1'b0; issue(5'd3, 5'd3, 5'd3, 8'h33); tick();
    idle(); tick();

    // r0 ignores a writeback to index 0; both operands share one index
    idle(); issue(5'd0, 5'd0, 5'd1, 8'h44); wb(5'd0, 32'hffff_ffff); tick();
    idle(); issue(5'd6, 5'd6, 5'd8, 8'h55); wb(5'd6, 32'h0bad_f00d); tick();
    idle(); tick();

    // Flush a held slot together with an incoming instruction
    idle(); bus.out_ready = 1'b0; issue(5'd1, 5'd2, 5'd2, 8'h66); tick();
    idle(); bus.out_ready = 1'b0; issue(5'd3, 5'd4, 5'd5, 8'h77); bus.flush = 1'b1; tick();
    idle(); issue(5'd5, 5'd4, 5'd9, 8'h88); tick();
    idle(); tick();

    // Reset while stalled
    idle(); bus.out_ready = 1'b0; issue(5'd6, 5'd7, 5'd1, 8'h99); tick();
    idle(); bus.out_ready = 1'b0; reset = 1'b1; tick();
    reset = 1'b0; idle(); bus.out_ready = 1'b0; tick();
    idle(); tick();

    // Random traffic over a small index range so hazards collide often
    repeat (3000) begin
      bus.in_valid     = ($urandom_range(0, 9) < 7);
      bus.in_rs1       = 5'($urandom_range(0, 7));
      bus.in_rs2       = 5'($urandom_range(0, 7));
      bus.in_rd        = 5'($urandom_range(0, 31));
      bus.in_ctrl      = 8'($urandom);
      bus.out_ready    = ($urandom_range(0, 9) < 6);
      bus.wb_regWrite  = ($urandom_range(0, 1) == 1);
      bus.wb_writeReg  = 5'($urandom_range(0, 7));
      bus.wb_writeData = $urandom;
      bus.flush        = ($urandom_range(0, 19) == 0);
      tick();
    end

    idle();
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
